// File: rtl/mod_inv_bin.sv
// rtl/mod_inv_bin.sv - sequential modular inverter (binary extended Euclid)
// One job at a time; the two halving lanes (u,x1) and (v,x2) advance together each RUN cycle.
module mod_inv_bin #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] q_i,
  input  logic [DATA_WIDTH-1:0] x_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] inv_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [DATA_WIDTH-1:0] r_q, r_u, r_v, r_x1, r_x2, r_inv;
  logic                  r_err;
  logic                  w_illegal, w_u_one, w_v_one, w_zero;

  // (a + q)/2 when a is odd keeps the lane value congruent to a/2 mod q.
  function automatic logic [DATA_WIDTH-1:0] half_mod(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] q);
    logic [DATA_WIDTH:0] s;
    s = a[0] ? ({1'b0, a} + {1'b0, q}) : {1'b0, a};
    return s[DATA_WIDTH:1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sub_mod(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b,
                                                    input logic [DATA_WIDTH-1:0] q);
    logic [DATA_WIDTH:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, a} + {1'b0, q} - {1'b0, b};
    return d[DATA_WIDTH-1:0];
  endfunction

  // In LOAD the lanes still hold the raw operands: u = x, v = q.
  assign w_illegal = ~r_q[0] || (r_q <= DATA_WIDTH'(1)) ||
                     (r_u == '0) || (r_u >= r_q);
  assign w_u_one   = (r_u == DATA_WIDTH'(1));
  assign w_v_one   = (r_v == DATA_WIDTH'(1));
  assign w_zero    = (r_u == '0) || (r_v == '0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_LOAD;
      S_LOAD:  w_next = w_illegal ? S_DONE : S_RUN;
      S_RUN:   if (w_u_one || w_v_one || w_zero) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q   <= '0;
      r_u   <= '0;
      r_v   <= '0;
      r_x1  <= '0;
      r_x2  <= '0;
      r_inv <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_q   <= q_i;
            r_u   <= x_i;
            r_v   <= q_i;
            r_x1  <= DATA_WIDTH'(1);
            r_x2  <= '0;
            r_inv <= '0;
            r_err <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_illegal) begin
            r_err <= 1'b1;
            r_inv <= '0;
          end
        end
        S_RUN: begin
          if (w_u_one) begin
            r_inv <= r_x1;
          end else if (w_v_one) begin
            r_inv <= r_x2;
          end else if (w_zero) begin
            r_err <= 1'b1;
            r_inv <= '0;
          end else if (!r_u[0] || !r_v[0]) begin
            if (!r_u[0]) begin
              r_u  <= r_u >> 1;
              r_x1 <= half_mod(r_x1, r_q);
            end
            if (!r_v[0]) begin
              r_v  <= r_v >> 1;
              r_x2 <= half_mod(r_x2, r_q);
            end
          end else if (r_u >= r_v) begin
            r_u  <= r_u - r_v;
            r_x1 <= sub_mod(r_x1, r_x2, r_q);
          end else begin
            r_v  <= r_v - r_u;
            r_x2 <= sub_mod(r_x2, r_x1, r_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (r_state == S_LOAD) || (r_state == S_RUN);
  assign done_o = (r_state == S_DONE);
  assign inv_o  = r_inv;
  assign err_o  = r_err;

endmodule

// File: tb/tb_mod_inv_bin.sv
// tb/tb_mod_inv_bin.sv - directed and small random checks for mod_inv_bin
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_mod_inv_bin;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] q = '0;
  logic [W-1:0] x = '0;
  logic         busy, done, err;
  logic [W-1:0] inv;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] r_inv_got;
  logic         r_err_got;
  int           cycles;
  logic         timed_out;
  logic         busy_gap;
  logic [W-1:0] big_q, big_exp;

  mod_inv_bin #(.DATA_WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(start),
    .q_i    (q),
    .x_i    (x),
    .busy_o (busy),
    .done_o (done),
    .inv_o  (inv),
    .err_o  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [W-1:0] qq, input logic [W-1:0] xx);
    @(negedge clk);
    q = qq;
    x = xx;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // cycles = index of the falling edge (counted from the start edge) at which done was seen.
  task automatic wait_done(input int limit);
    timed_out = 1'b1;
    busy_gap  = 1'b0;
    cycles    = 0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (done) begin
        cycles    = k;
        timed_out = 1'b0;
        break;
      end
      if (!busy) busy_gap = 1'b1;
    end
    r_inv_got = inv;
    r_err_got = err;
    check("timeout", W'(timed_out), W'(0));
  endtask

  task automatic job(input logic [W-1:0] qq, input logic [W-1:0] xx);
    start_job(qq, xx);
    wait_done(600);
  endtask

  function automatic longint unsigned gcd(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  initial begin
    big_q   = {1'b0, {(W-1){1'b1}}};
    big_exp = W'(1) << 126;

    #12;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_inv", inv, W'(0));
    check("rst_err", W'(err), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    job(W'(7), W'(3));
    check("q7x3_inv", r_inv_got, W'(5));
    check("q7x3_err", W'(r_err_got), W'(0));
    check("q7x3_busy", W'(busy_gap), W'(0));
    @(negedge clk);
    check("q7x3_done_pulse", W'(done), W'(0));
    check("q7x3_hold", inv, W'(5));

    job(W'(13), W'(1));
    check("q13x1_inv", r_inv_got, W'(1));
    check("q13x1_lat", W'(cycles), W'(3));
    job(W'(13), W'(12));
    check("q13x12_inv", r_inv_got, W'(12));
    for (int i = 1; i <= 12; i++) begin
      job(W'(13), W'(i));
      check($sformatf("sweep13_x%0d", i), (W'(i) * r_inv_got) % W'(13), W'(1));
      check($sformatf("sweep13_err%0d", i), W'(r_err_got), W'(0));
    end

    job(big_q, W'(2));
    check("big_inv", r_inv_got, big_exp);
    check("big_lat", W'(cycles <= 515), W'(1));

    job(W'(9), W'(3));
    check("gcd3_err", W'(r_err_got), W'(1));
    check("gcd3_inv", r_inv_got, W'(0));
    job(W'(7), W'(0));
    check("x0_err", W'(r_err_got), W'(1));
    check("x0_inv", r_inv_got, W'(0));
    job(W'(8), W'(3));
    check("qeven_err", W'(r_err_got), W'(1));
    check("qeven_inv", r_inv_got, W'(0));
    job(W'(7), W'(9));
    check("xbig_err", W'(r_err_got), W'(1));
    check("xbig_inv", r_inv_got, W'(0));

    // Second start mid-job must be ignored.
    start_job(big_q, W'(2));
    repeat (3) @(negedge clk);
    q = W'(7);
    x = W'(3);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(600);
    check("restart_inv", r_inv_got, big_exp);
    check("restart_err", W'(r_err_got), W'(0));
    // Start held during the DONE cycle is ignored.
    q = W'(7);
    x = W'(3);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("done_start_ignored", W'(busy), W'(0));
    check("done_start_hold", inv, big_exp);
    // Start in the cycle right after the DONE cycle is accepted.
    start_job(W'(7), W'(3));
    @(negedge clk);
    check("after_done_busy", W'(busy), W'(1));
    wait_done(600);
    check("after_done_inv", r_inv_got, W'(5));

    job(W'(7), W'(3));
    start_job(big_q, W'(2));
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", W'(busy), W'(0));
    check("arst_done", W'(done), W'(0));
    check("arst_inv", inv, W'(0));
    check("arst_err", W'(err), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    job(W'(11), W'(3));
    check("post_rst_inv", r_inv_got, W'(4));

    for (int n = 0; n < 100; n++) begin
      longint unsigned qq, xx, g;
      qq = longint'($urandom_range(3, 65535)) | 64'd1;
      xx = longint'($urandom_range(1, 32'(qq - 1)));
      g  = gcd(qq, xx);
      job(W'(qq), W'(xx));
      if (g == 1) begin
        check("rnd_mul", (W'(xx) * r_inv_got) % W'(qq), W'(1));
        check("rnd_range", W'(r_inv_got < W'(qq)), W'(1));
      end else begin
        check("rnd_err", W'(r_err_got), W'(1));
        check("rnd_errinv", r_inv_got, W'(0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
